// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-file arbiter: FSM encoding,
// requester indices and the default access timeout.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_ACCESS = 3'b010,
    ST_RESP   = 3'b100
  } arb_state_t;

  localparam int   NUM_REQ             = 2;
  localparam logic REQ_M0              = 1'b0;  // APB bridge
  localparam logic REQ_M1              = 1'b1;  // SPI core
  localparam int   SPI_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/spi_rr_arb.sv
// Two-requester round-robin pick: a lone request always wins, a tie goes
// to the requester that was not granted last.
module spi_rr_arb
  import spi_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_gnt,
  output logic               gnt,
  output logic               vld
);

  always_comb begin
    vld = |req;
    if (&req) gnt = ~last_gnt;
    else      gnt = req[REQ_M1];
  end

endmodule

// File: rtl/spi_reg_arb.sv
// Arbitrates APB-bridge and SPI-core accesses onto one register-file port,
// with an access timeout and abort on requester withdrawal.
module spi_reg_arb
  import spi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = SPI_TIMEOUT_DEFAULT
) (
  input  logic                  apb_clk_in,
  input  logic                  apb_rstn_in,
  input  logic                  m0_sel_in,
  input  logic                  m0_write_in,
  input  logic [ADDR_WIDTH-1:0] m0_addr_in,
  input  logic [DATA_WIDTH-1:0] m0_wdata_in,
  output logic                  m0_ready_out,
  output logic                  m0_error_out,
  output logic [DATA_WIDTH-1:0] m0_rdata_out,
  input  logic                  m1_sel_in,
  input  logic                  m1_write_in,
  input  logic [ADDR_WIDTH-1:0] m1_addr_in,
  input  logic [DATA_WIDTH-1:0] m1_wdata_in,
  output logic                  m1_ready_out,
  output logic                  m1_error_out,
  output logic [DATA_WIDTH-1:0] m1_rdata_out,
  output logic                  slv_sel_out,
  output logic                  slv_write_out,
  output logic [ADDR_WIDTH-1:0] slv_addr_out,
  output logic [DATA_WIDTH-1:0] slv_wdata_out,
  input  logic                  slv_ready_in,
  input  logic                  slv_error_in,
  input  logic [DATA_WIDTH-1:0] slv_rdata_in
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_REQ-1:0]                 req;
  logic [NUM_REQ-1:0]                 req_write;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;

  assign req       = {m1_sel_in,   m0_sel_in};
  assign req_write = {m1_write_in, m0_write_in};
  assign req_addr  = {m1_addr_in,  m0_addr_in};
  assign req_wdata = {m1_wdata_in, m0_wdata_in};

  arb_state_t            state_q, state_d;
  logic                  last_q, gnt_q;
  logic                  rr_gnt, rr_vld;
  logic [CW-1:0]         cnt_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  grant_en, done, tmo, abort;

  spi_rr_arb u_rr (
    .req      (req),
    .last_gnt (last_q),
    .gnt      (rr_gnt),
    .vld      (rr_vld)
  );

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Withdrawal beats a same-cycle ready; ready beats a same-cycle timeout.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;
    abort    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rr_vld) begin
          grant_en = 1'b1;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!req[gnt_q]) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (slv_ready_in) begin
          done    = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          tmo     = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      last_q        <= REQ_M1;
      gnt_q         <= REQ_M0;
      slv_sel_out   <= 1'b0;
      slv_write_out <= 1'b0;
      slv_addr_out  <= '0;
      slv_wdata_out <= '0;
      cnt_q         <= '0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      if (grant_en) begin
        gnt_q         <= rr_gnt;
        last_q        <= rr_gnt;
        slv_sel_out   <= 1'b1;
        slv_write_out <= req_write[rr_gnt];
        slv_addr_out  <= req_addr[rr_gnt];
        slv_wdata_out <= req_wdata[rr_gnt];
        cnt_q         <= '0;
      end
      if (state_q == ST_ACCESS && !slv_ready_in && !abort)
        cnt_q <= cnt_q + CW'(1);
      if (abort || done || tmo)
        slv_sel_out <= 1'b0;
      if (done) begin
        rsp_err_q   <= slv_error_in;
        rsp_rdata_q <= (slv_write_out || slv_error_in) ? '0 : slv_rdata_in;
      end else if (tmo) begin
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= '0;
      end
    end
  end

  logic in_resp;
  assign in_resp = (state_q == ST_RESP);

  assign m0_ready_out = in_resp && (gnt_q == REQ_M0);
  assign m1_ready_out = in_resp && (gnt_q == REQ_M1);
  assign m0_error_out = m0_ready_out && rsp_err_q;
  assign m1_error_out = m1_ready_out && rsp_err_q;
  assign m0_rdata_out = m0_ready_out ? rsp_rdata_q : '0;
  assign m1_rdata_out = m1_ready_out ? rsp_rdata_q : '0;

endmodule

// File: doc/spi_reg_arb.md
SPI_REG_ARB -- requirements
Module: spi_reg_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of register address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of register data.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS cycles before forced error.
REQ-004 SHALL have port apb_clk_in, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port apb_rstn_in, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports m0_sel_in / m1_sel_in, input, 1, requester 0 (APB bridge) / requester 1 (SPI core) access request, held until its ready pulse.
REQ-007 SHALL have ports mN_write_in (1), mN_addr_in (ADDR_WIDTH), mN_wdata_in (DATA_WIDTH), inputs, per requester, stable while mN_sel_in high.
REQ-008 SHALL have ports mN_ready_out (1), mN_error_out (1), mN_rdata_out (DATA_WIDTH), outputs, per requester, response.
REQ-009 SHALL have ports slv_sel_out (1), slv_write_out (1), slv_addr_out (ADDR_WIDTH), slv_wdata_out (DATA_WIDTH), outputs, shared register-file access.
REQ-010 SHALL have ports slv_ready_in (1), slv_error_in (1), slv_rdata_in (DATA_WIDTH), inputs, register-file response.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RESP; one-hot encoding.
REQ-012 IDLE: any mN_sel_in high -> latch winner's write/addr/wdata into slv_* outputs, assert slv_sel_out, go ACCESS next cycle.
REQ-013 Both requests high in IDLE -> grant requester not granted last (round-robin); single request -> grant it regardless of history.
REQ-014 ACCESS: slv_ready_in high -> capture slv_error_in and rdata, deassert slv_sel_out, go RESP.
REQ-015 RESP: granted mN_ready_out high exactly one cycle, other requester's ready_out low; then IDLE.
REQ-016 mN_rdata_out SHALL be slv_rdata_in captured value for reads without error, 0 for writes or error.
REQ-017 mN_error_out SHALL equal captured slv_error_in during RESP, 0 otherwise.
REQ-018 Wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle without slv_ready_in.
REQ-019 Counter reaching TIMEOUT_CYCLES -> deassert slv_sel_out, go RESP with error_out=1, rdata_out=0.
REQ-020 Granted mN_sel_in falling during ACCESS -> abort: slv_sel_out low next cycle, IDLE, no ready pulse; last-grant still updated.
REQ-021 slv_ready_in and timeout in same cycle -> ready wins, normal response.
REQ-022 Non-granted request SHALL wait; served in next IDLE cycle if still asserted.
REQ-023 Minimum latency: sel sampled cycle N -> slv_sel_out high N+1 -> with immediate ready, mN_ready_out high N+2.
REQ-024 slv_addr_out/wdata_out/write_out SHALL hold latched values outside ACCESS.

Reset
REQ-025 Reset asserted SHALL force IDLE, all outputs 0, counter 0, last-grant = requester 1 (so requester 0 wins first tie).
REQ-026 Reset mid-ACCESS SHALL drop slv_sel_out immediately (asynchronous), no response issued.

Structure
REQ-027 State encodings, requester index constants and TIMEOUT default SHALL live in shared package spi_pkg.
REQ-028 Round-robin winner selection SHALL be sub-module spi_rr_arb (two requests, last-grant in, grant out, combinational).

Verification
REQ-029 m0 read addr 0x08, slave ready after 2 cycles rdata 0xA5A5_0001 -> m0_ready_out one cycle, m0_rdata_out 0xA5A5_0001, error 0.
REQ-030 m0 and m1 requesting same cycle after reset, both held -> m0 served first, then m1; repeat tie -> m1 then m0.
REQ-031 m1 write addr 0x10 data 0x1234, slave never ready -> slv_sel_out low after 16 ACCESS cycles, m1_ready_out and m1_error_out 1, rdata 0.
REQ-032 m0 read, slave ready with slv_error_in=1 rdata 0xFFFF_FFFF -> m0_error_out 1, m0_rdata_out 0.
REQ-033 m0_sel_in dropped in 2nd ACCESS cycle -> slv_sel_out low next cycle, no m0_ready_out, pending m1 granted following IDLE.
REQ-034 apb_rstn_in low mid-ACCESS -> all outputs 0 same cycle; after release, m0 request served normally.
